car_parking: RTL and testbench

// - Occupancy counter for a parking lot with a fixed number of bays.
// - Entry and exit sensors each produce a pulse per vehicle; the block keeps
//   a saturating count of parked cars and flags when the lot is full or empty.
// - Sits between the gate sensor conditioning logic and the display/barrier

---
 rtl/car_parking_pkg.sv | 24 ++
 rtl/car_parking_edge_det.sv | 22 ++
 rtl/car_parking.sv | 61 ++++++
 tb/tb_car_parking.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/car_parking_pkg.sv
// Shared types for the parking occupancy counter: the per-cycle counter action
// and the rule that turns sensor events plus boundary flags into that action.
package car_parking_pkg;

    typedef enum logic [1:0] {
        ACT_HOLD = 2'd0,
        ACT_INC  = 2'd1,
        ACT_DEC  = 2'd2
    } park_act_e;

    // Simultaneous entry and exit cancel out; saturation at either end holds the count.
    function automatic park_act_e park_action(input logic in_evt, input logic out_evt,
                                              input logic at_full, input logic at_empty);
        park_act_e act;
        act = ACT_HOLD;
        if (in_evt && !out_evt && !at_full) begin
            act = ACT_INC;
        end else if (out_evt && !in_evt && !at_empty) begin
            act = ACT_DEC;
        end
        return act;
    endfunction

endpackage

// File: rtl/car_parking_edge_det.sv
// One-bit rising-edge detector: the event fires on the first clock edge a high
// level is sampled, so a level held for many cycles yields a single event.
module park_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic sig_i,
    output logic evt_o
);

    logic prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= sig_i;
        end
    end

    assign evt_o = sig_i & ~prev_q;

endmodule

// File: rtl/car_parking.sv
// Parking-lot occupancy counter: edge-detected entry/exit sensors drive a
// saturating up/down count with full/empty decode of the count register.
module car_parking
    import car_parking_pkg::*;
#(
    parameter int CAPACITY = 10,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             car_in,
    input  logic             car_out,
    output logic [CNT_W-1:0] counter,
    output logic             full,
    output logic             empty
);

    localparam logic [CNT_W-1:0] CAP = CNT_W'(CAPACITY);

    logic [1:0]       sens;
    logic [1:0]       evt;
    logic [CNT_W-1:0] counter_q;
    logic [CNT_W-1:0] counter_d;
    park_act_e        act;

    assign sens = {car_out, car_in};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_edge
            park_edge_det u_edge (
                .clk   (clk),
                .rst   (reset),
                .sig_i (sens[gi]),
                .evt_o (evt[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            counter_q <= '0;
        end else begin
            counter_q <= counter_d;
        end
    end

    always_comb begin
        act       = park_action(evt[0], evt[1], full, empty);
        counter_d = counter_q;
        case (act)
            ACT_INC: counter_d = counter_q + 1'b1;
            ACT_DEC: counter_d = counter_q - 1'b1;
            default: counter_d = counter_q;
        endcase
    end

    assign counter = counter_q;
    assign full    = (counter_q == CAP);
    assign empty   = (counter_q == '0);

endmodule

// File: tb/tb_car_parking.sv
// Self-checking bench for car_parking: directed scenarios plus random sensor
// traffic, all compared against a simple occupancy model kept in the bench.
module tb_car_parking;

    localparam int CAP = 10;
    localparam int CW  = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          car_in;
    logic          car_out;
    logic [CW-1:0] counter;
    logic          full;
    logic          empty;

    int n_total = 0;
    int n_bad   = 0;

    // Model: number of parked cars and last sampled sensor levels.
    int   m_count   = 0;
    logic m_prev_in = 1'b0;
    logic m_prev_out = 1'b0;

    car_parking #(.CAPACITY(CAP), .CNT_W(CW)) dut (
        .clk     (clk),
        .reset   (reset),
        .car_in  (car_in),
        .car_out (car_out),
        .counter (counter),
        .full    (full),
        .empty   (empty)
    );

    always #5 clk = ~clk;

    // Drive one clock of sensor levels, advance the model, sample 1ns after the edge.
    task automatic cycle(input logic i, input logic o);
        logic ie, oe;
        car_in  = i;
        car_out = o;
        ie = i && !m_prev_in;
        oe = o && !m_prev_out;
        if (ie && !oe && m_count < CAP) m_count++;
        else if (oe && !ie && m_count > 0) m_count--;
        m_prev_in  = i;
        m_prev_out = o;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        car_in  = 1'b0;
        car_out = 1'b0;
        #10;
        reset = 1'b0;
        m_count = 0; m_prev_in = 1'b0; m_prev_out = 1'b0;
        @(posedge clk);
        #1;
        n_total++;
        if (counter !== 4'd0) begin
            n_bad++; $display("FAIL reset_counter got=%0d want=0", counter);
        end
        n_total++;
        if (empty !== 1'b1) begin
            n_bad++; $display("FAIL reset_empty got=%b want=1", empty);
        end
        n_total++;
        if (full !== 1'b0) begin
            n_bad++; $display("FAIL reset_full got=%b want=0", full);
        end
    endtask

    task automatic test_single();
        cycle(1'b1, 1'b0);
        n_total++;
        if (counter !== 4'd1 || empty !== 1'b0) begin
            n_bad++; $display("FAIL single_in got=%0d/e%b want=1/e0", counter, empty);
        end
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b1);
        n_total++;
        if (counter !== 4'd0 || empty !== 1'b1) begin
            n_bad++; $display("FAIL single_out got=%0d/e%b want=0/e1", counter, empty);
        end
        cycle(1'b0, 1'b0);
    endtask

    task automatic test_fill();
        for (int k = 0; k < 11; k++) begin
            cycle(1'b1, 1'b0);
            cycle(1'b0, 1'b0);
            n_total++;
            if (counter !== CW'(m_count) || full !== (m_count == CAP) || empty !== (m_count == 0)) begin
                n_bad++;
                $display("FAIL fill_step%0d got=%0d/f%b/e%b want=%0d", k, counter, full, empty, m_count);
            end
        end
        n_total++;
        if (counter !== 4'd10 || full !== 1'b1) begin
            n_bad++; $display("FAIL fill_saturate got=%0d/f%b want=10/f1", counter, full);
        end
    endtask

    // From full: 5 out, 5 in, 10 out, 1 extra out.
    task automatic test_drain();
        int plan_n[4]  = '{5, 5, 10, 1};
        logic plan_in[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        int want[4]    = '{5, 10, 0, 0};
        for (int p = 0; p < 4; p++) begin
            for (int k = 0; k < plan_n[p]; k++) begin
                cycle(plan_in[p], !plan_in[p]);
                cycle(1'b0, 1'b0);
            end
            n_total++;
            if (counter !== CW'(want[p]) || full !== (want[p] == CAP) || empty !== (want[p] == 0)) begin
                n_bad++;
                $display("FAIL drain_phase%0d got=%0d/f%b/e%b want=%0d", p, counter, full, empty, want[p]);
            end
        end
    endtask

    task automatic test_hold();
        for (int k = 0; k < 5; k++) cycle(1'b1, 1'b0);
        n_total++;
        if (counter !== 4'd1) begin
            n_bad++; $display("FAIL hold_level got=%0d want=1", counter);
        end
        cycle(1'b0, 1'b0);
        n_total++;
        if (counter !== 4'd1) begin
            n_bad++; $display("FAIL hold_fall got=%0d want=1", counter);
        end
    endtask

    task automatic test_simultaneous();
        int targets[3] = '{3, 0, 10};
        for (int t = 0; t < 3; t++) begin
            while (m_count != targets[t]) begin
                if (m_count < targets[t]) cycle(1'b1, 1'b0);
                else cycle(1'b0, 1'b1);
                cycle(1'b0, 1'b0);
            end
            cycle(1'b1, 1'b1);
            n_total++;
            if (counter !== CW'(targets[t]) || full !== (targets[t] == CAP) || empty !== (targets[t] == 0)) begin
                n_bad++;
                $display("FAIL simul_at%0d got=%0d/f%b/e%b want=%0d", targets[t], counter, full, empty, targets[t]);
            end
            cycle(1'b0, 1'b0);
        end
    endtask

    task automatic test_async_reset();
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);
        n_total++;
        if (counter !== 4'd9) begin
            n_bad++; $display("FAIL pre_reset got=%0d want=9", counter);
        end
        #3;
        reset = 1'b1;
        #1;
        n_total++;
        if (counter !== 4'd0 || empty !== 1'b1 || full !== 1'b0) begin
            n_bad++; $display("FAIL async_reset got=%0d/f%b/e%b want=0/f0/e1", counter, full, empty);
        end
        #1;
        reset = 1'b0;
        m_count = 0; m_prev_in = 1'b0; m_prev_out = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            n_total++;
            if (counter !== CW'(m_count) || full !== (m_count == CAP) || empty !== (m_count == 0)) begin
                n_bad++;
                $display("FAIL random_cyc%0d got=%0d/f%b/e%b want=%0d", k, counter, full, empty, m_count);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_drain();
        test_hold();
        test_simultaneous();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
